// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one comparison unit between two requesters,
// with valid/ready request and response handshakes and registered operands/flags.

module comp_top #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              is_signed,
    output logic              gt,
    output logic              lt,
    output logic              et
);

    // Magnitude compare, signedness selected per operation
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        et = (in0 == in1);
        if (is_signed) begin
            gt = ($signed(in0) > $signed(in1));
            lt = ($signed(in0) < $signed(in1));
        end else begin
            gt = (in0 > in1);
            lt = (in0 < in1);
        end
    end

endmodule

module comp_arbiter #(
    parameter int DATA_W     = 16,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_signed,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_gt,
    output logic              rsp_lt,
    output logic              rsp_et,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              prio_r;
    logic              grant_s;
    logic              accept_s;
    logic              rsp_done_s;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic              op_signed_r;
    logic              op_id_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic              rsp_gt_r;
    logic              rsp_lt_r;
    logic              rsp_et_r;
    logic              busy_r;
    logic              cmp_gt_s;
    logic              cmp_lt_s;
    logic              cmp_et_s;

    // Grant selection: priority holder wins a tie, otherwise the lone requester
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = prio_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = (state_r == ST_IDLE) & ~grant_s & req0_valid;
    assign req1_ready = (state_r == ST_IDLE) & grant_s & req1_valid;
    assign accept_s   = req0_ready | req1_ready;
    assign rsp_done_s = rsp_valid_r & rsp_ready;

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CMP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMP:  state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture on request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r      <= {DATA_W{1'b0}};
            op_b_r      <= {DATA_W{1'b0}};
            op_signed_r <= 1'b0;
            op_id_r     <= 1'b0;
        end else if (accept_s) begin
            op_a_r      <= grant_s ? req1_a : req0_a;
            op_b_r      <= grant_s ? req1_b : req0_b;
            op_signed_r <= grant_s ? req1_signed : req0_signed;
            op_id_r     <= grant_s;
        end
    end

    comp_top #(.DATA_W(DATA_W)) u_comp_top (
        .in0       (op_a_r),
        .in1       (op_b_r),
        .is_signed (op_signed_r),
        .gt        (cmp_gt_s),
        .lt        (cmp_lt_s),
        .et        (cmp_et_s)
    );

    // Response capture; priority flips to the other requester only once a response completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_gt_r    <= 1'b0;
            rsp_lt_r    <= 1'b0;
            rsp_et_r    <= 1'b0;
            prio_r      <= PRIO_RESET;
        end else if (state_r == ST_CMP) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= op_id_r;
            rsp_gt_r    <= cmp_gt_s;
            rsp_lt_r    <= cmp_lt_s;
            rsp_et_r    <= cmp_et_s;
        end else if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
            prio_r      <= ~rsp_id_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_gt    = rsp_gt_r;
    assign rsp_lt    = rsp_lt_r;
    assign rsp_et    = rsp_et_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_comp_arbiter.sv
// Scoreboard bench for comp_arbiter: expected {id,gt,lt,et} queued at stimulus time,
// checked at each response handshake; latency, stall and reset behaviour checked inline.

module tb_comp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_signed;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_signed;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_gt, rsp_lt, rsp_et, busy;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         acc_cyc = 0;
    bit         pend  = 1'b0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    comp_arbiter #(.DATA_W(16), .PRIO_RESET(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_signed (req0_signed),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_signed (req1_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_gt      (rsp_gt),
        .rsp_lt      (rsp_lt),
        .rsp_et      (rsp_et),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] cmp_ref(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [16:0] sa, sb;
        sa = s ? {a[15], a} : {1'b0, a};
        sb = s ? {b[15], b} : {1'b0, b};
        return {sa > sb, sa < sb, sa == sb};
    endfunction

    // Response monitor: one-hot flags, T+2 latency, scoreboard compare
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (rsp_valid)
                check("onehot", $countones({rsp_gt, rsp_lt, rsp_et}), 32'd1);
            if (pend && rsp_valid) begin
                check("latency", cyc - acc_cyc, 32'd2);
                pend = 1'b0;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                check("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
                acc_cyc = cyc;
                pend    = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, e[3]});
                    check("rsp_flags", {29'd0, rsp_gt, rsp_lt, rsp_et}, {29'd0, e[2:0]});
                end
            end
        end
    end

    // Present requests and hold each valid until its handshake
    task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic s1);
        logic r0, r1;
        if (v0) begin req0_a = a0; req0_b = b0; req0_signed = s0; req0_valid = 1'b1; end
        if (v1) begin req1_a = a1; req1_b = b1; req1_signed = s1; req1_valid = 1'b1; end
        for (int i = 0; i < 40 && (req0_valid || req1_valid); i++) begin
            @(negedge clk);
            r0 = req0_ready;
            r1 = req1_ready;
            @(posedge clk);
            #1;
            if (r0) req0_valid = 1'b0;
            if (r1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            check("accept_timeout", 32'd1, 32'd0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = 16'd0; req0_b = 16'd0; req0_signed = 1'b0;
        req1_valid = 1'b0; req1_a = 16'd0; req1_b = 16'd0; req1_signed = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
        check("rst_flags",     {29'd0, rsp_gt, rsp_lt, rsp_et}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single unsigned request
        exp_q.push_back({1'b0, cmp_ref(16'd5, 16'd3, 1'b0)});
        drive(1'b1, 16'd5, 16'd3, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        wait_idle();

        // 2: simultaneous request right after reset goes to requester 0
        reset_pulse();
        exp_q.push_back({1'b0, cmp_ref(16'd7, 16'd7, 1'b0)});
        exp_q.push_back({1'b1, cmp_ref(16'hFFFF, 16'd5, 1'b1)});
        drive(1'b1, 16'd7, 16'd7, 1'b0, 1'b1, 16'hFFFF, 16'd5, 1'b1);
        wait_idle();

        // 3: both held valid, alternation 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, cmp_ref(16'(k * 3), 16'd4, 1'b0)});
            exp_q.push_back({1'b1, cmp_ref(16'hFFF0, 16'(k), 1'b1)});
            drive(1'b1, 16'(k * 3), 16'd4, 1'b0, 1'b1, 16'hFFF0, 16'(k), 1'b1);
        end
        wait_idle();

        // 4: response stall with a competing request pending
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, cmp_ref(16'h1234, 16'h0034, 1'b0)});
        drive(1'b1, 16'h1234, 16'h0034, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        exp_q.push_back({1'b1, cmp_ref(16'd3, 16'd9, 1'b1)});
        req1_a = 16'd3; req1_b = 16'd9; req1_signed = 1'b1; req1_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("stall_rsp_seen", {31'd0, seen}, 32'd1);
        repeat (5) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_id",    {31'd0, rsp_id},    32'd0);
            check("stall_flags", {29'd0, rsp_gt, rsp_lt, rsp_et}, {29'd0, cmp_ref(16'h1234, 16'h0034, 1'b0)});
            check("stall_rdy0",  {31'd0, req0_ready}, 32'd0);
            check("stall_rdy1",  {31'd0, req1_ready}, 32'd0);
            check("stall_busy",  {31'd0, busy},       32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd3, 16'd9, 1'b1);
        wait_idle();

        // 5: signedness per request
        exp_q.push_back({1'b0, cmp_ref(16'hFFFF, 16'h0005, 1'b0)});
        drive(1'b1, 16'hFFFF, 16'h0005, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        exp_q.push_back({1'b0, cmp_ref(16'hFFFF, 16'h0005, 1'b1)});
        drive(1'b1, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        exp_q.push_back({1'b0, cmp_ref(16'hFFFE, 16'hFFFB, 1'b1)});
        drive(1'b1, 16'hFFFE, 16'hFFFB, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        wait_idle();

        // 6: reset during CMP drops the transaction and restores priority
        drive(1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_busy",  {31'd0, busy},      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, cmp_ref(16'd9, 16'd2, 1'b0)});
        exp_q.push_back({1'b1, cmp_ref(16'h8000, 16'h7FFF, 1'b1)});
        drive(1'b1, 16'd9, 16'd2, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        wait_idle();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
